// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage in-order pipeline.
// Stalls and flushes on data-cache misses, taken branches and RAW hazards,
// selects EX operand forwarding and counts fetch-stall cycles.
// Build option: define HAZARD_FORWARDING_EN to enable MEM/WB operand
// forwarding; without it every non-zero RAW match against EX or MEM stalls
// and forwardAE/forwardBE stay 00.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic [4:0]  rdM,
    input  logic [4:0]  rdW,
    input  logic        regWriteE,
    input  logic        regWriteM,
    input  logic        regWriteW,
    input  logic [1:0]  resultSrcE,
    input  logic        pcSrcE,
    input  logic        memAccessM,
    input  logic        cacheMissM,
    input  logic        cacheReadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushW,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic [31:0] stallCount
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] MISS   = 2'b01;
    localparam logic [1:0] REFILL = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             mem_stall;
    logic             hit_e;
    logic             data_hazard;

`ifdef HAZARD_FORWARDING_EN
    localparam logic [1:0] RES_LOAD = 2'b01;

    // Operand source for one EX operand; MEM result is newer than WB
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (regWriteM && (rdM != 5'd0) && (rdM == rs)) begin
            return FWD_MEM;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction
`else
    logic hit_m;
    logic unused_fwd_inputs;

    // EX-side operand and WB inputs only matter when forwarding is built in
    assign unused_fwd_inputs = ^{rs1E, rs2E, rdW, regWriteW, resultSrcE};
`endif

    // Next state of the data-cache miss FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (memAccessM && cacheMissM) state_d = MISS;
            MISS:    if (cacheReadyM) state_d = REFILL;
            REFILL:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Fetch-stall cycle counter, saturating at all ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // FSM state and stall counter; rst abandons any miss in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Classify the current cycle's hazards
    always_comb begin
        mem_stall = (state_q != RUN) || (memAccessM && cacheMissM);
        hit_e     = regWriteE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
`ifdef HAZARD_FORWARDING_EN
        data_hazard = hit_e && (resultSrcE == RES_LOAD);
`else
        hit_m       = regWriteM && (rdM != 5'd0) && ((rdM == rs1D) || (rdM == rs2D));
        data_hazard = hit_e || hit_m;
`endif
    end

    // Stall/flush response: memory stall beats branch flush beats RAW stall
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (pcSrcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (data_hazard) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    // EX operand forwarding selects
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
`ifdef HAZARD_FORWARDING_EN
        if (!rst) begin
            forwardAE = fwd_sel(rs1E);
            forwardBE = fwd_sel(rs2E);
        end
`endif
    end

    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (scoreboard of per-cycle
// expected outputs). Expectations follow HAZARD_FORWARDING_EN if defined.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regWriteE, regWriteM, regWriteW;
    logic [1:0]  resultSrcE;
    logic        pcSrcE, memAccessM, cacheMissM, cacheReadyM;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stallCount;

    typedef struct packed {
        logic [6:0]  flags;   // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] MEM  = 7'b1111001;
    localparam logic [6:0] BR   = 7'b0000110;
`ifdef HAZARD_FORWARDING_EN
    localparam logic [6:0] RAW   = NONE;
    localparam logic [1:0] F_MEM = 2'b10;
    localparam logic [1:0] F_WB  = 2'b01;
`else
    localparam logic [6:0] RAW   = LU;
    localparam logic [1:0] F_MEM = 2'b00;
    localparam logic [1:0] F_WB  = 2'b00;
`endif

    exp_t        exp_q[$];
    logic [31:0] model_cnt;
    int          checks = 0;
    int          errors = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .resultSrcE(resultSrcE), .pcSrcE(pcSrcE),
        .memAccessM(memAccessM), .cacheMissM(cacheMissM), .cacheReadyM(cacheReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t obs();
        exp_t r;
        r.flags = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
        r.fa    = forwardAE;
        r.fb    = forwardBE;
        r.cnt   = stallCount;
        return r;
    endfunction

    // Queue this cycle's expected outputs; counter sees stallF at the next edge
    task automatic push_exp(input logic [6:0] flags, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.flags = flags;
        e.fa    = fa;
        e.fb    = fb;
        e.cnt   = model_cnt;
        exp_q.push_back(e);
        if (flags[6] && (model_cnt != 32'hFFFF_FFFF)) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
        resultSrcE = 2'b00; pcSrcE = 1'b0;
        memAccessM = 1'b0; cacheMissM = 1'b0; cacheReadyM = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        exp_q.delete();
        model_cnt = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_use_5();
        resultSrcE = 2'b01; regWriteE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1;
        model_cnt = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            load_use_5();
            pcSrcE = 1'b1; memAccessM = 1'b1; cacheMissM = 1'b1;
            regWriteM = 1'b1; rdM = 5'd7; rs1E = 5'd7;
            regWriteW = 1'b1; rdW = 5'd8; rs2E = 5'd8;
            push_exp(NONE, 2'b00, 2'b00);
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_load_use();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin load_use_5(); push_exp(LU, 2'b00, 2'b00); end
                1: push_exp(NONE, 2'b00, 2'b00);
                2: begin resultSrcE = 2'b01; regWriteE = 1'b1; rdE = 5'd5; rs2D = 5'd5;
                         push_exp(LU, 2'b00, 2'b00); end
                3: begin resultSrcE = 2'b01; regWriteE = 1'b1; push_exp(NONE, 2'b00, 2'b00); end
                4: begin resultSrcE = 2'b01; rdE = 5'd6; rs1D = 5'd6; push_exp(NONE, 2'b00, 2'b00); end
                default: begin resultSrcE = 2'b01; regWriteE = 1'b1; rdE = 5'd6;
                         rs1D = 5'd7; rs2D = 5'd8; push_exp(NONE, 2'b00, 2'b00); end
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL load_use[%0d]: got %h want %h", i, o, e); end
        end
        checks++;
        if (stallCount !== 32'd2) begin
            errors++; $display("FAIL load_use_count: got %0d want 2", stallCount);
        end
    endtask

    task automatic test_forwarding();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin regWriteM = 1'b1; rdM = 5'd7; regWriteW = 1'b1; rdW = 5'd7; rs1E = 5'd7;
                         push_exp(NONE, F_MEM, 2'b00); end
                1: begin rdM = 5'd7; regWriteW = 1'b1; rdW = 5'd7; rs1E = 5'd7;
                         push_exp(NONE, F_WB, 2'b00); end
                2: begin regWriteM = 1'b1; regWriteW = 1'b1; push_exp(NONE, 2'b00, 2'b00); end
                3: begin regWriteM = 1'b1; rdM = 5'd7; rs1E = 5'd7;
                         regWriteW = 1'b1; rdW = 5'd9; rs2E = 5'd9;
                         push_exp(NONE, F_MEM, F_WB); end
                default: begin regWriteM = 1'b1; rdM = 5'd9; regWriteW = 1'b1; rdW = 5'd9;
                         rs2E = 5'd9; rs1E = 5'd3; push_exp(NONE, 2'b00, F_MEM); end
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL forwarding[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_miss();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0, 1: begin memAccessM = 1'b1; cacheMissM = 1'b1; push_exp(MEM, 2'b00, 2'b00); end
                2: begin memAccessM = 1'b1; cacheMissM = 1'b1; pcSrcE = 1'b1;
                         push_exp(MEM, 2'b00, 2'b00); end
                3: begin memAccessM = 1'b1; cacheMissM = 1'b1; load_use_5();
                         push_exp(MEM, 2'b00, 2'b00); end
                4: begin memAccessM = 1'b1; cacheMissM = 1'b1; cacheReadyM = 1'b1;
                         push_exp(MEM, 2'b00, 2'b00); end
                5: begin memAccessM = 1'b1; push_exp(MEM, 2'b00, 2'b00); end
                default: push_exp(NONE, 2'b00, 2'b00);
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL miss[%0d]: got %h want %h", i, o, e); end
        end
        checks++;
        if (stallCount !== 32'd6) begin
            errors++; $display("FAIL miss_count: got %0d want 6", stallCount);
        end
    endtask

    task automatic test_branch_priority();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin pcSrcE = 1'b1; load_use_5(); push_exp(BR, 2'b00, 2'b00); end
                1: begin pcSrcE = 1'b1; memAccessM = 1'b1; cacheMissM = 1'b1;
                         push_exp(MEM, 2'b00, 2'b00); end
                2: begin cacheReadyM = 1'b1; push_exp(MEM, 2'b00, 2'b00); end
                3: push_exp(MEM, 2'b00, 2'b00);
                default: push_exp(NONE, 2'b00, 2'b00);
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL branch[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_reset_mid_miss();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0, 1: begin memAccessM = 1'b1; cacheMissM = 1'b1; push_exp(MEM, 2'b00, 2'b00); end
                2, 3: begin rst = 1'b1; model_cnt = '0; memAccessM = 1'b1; cacheMissM = 1'b1;
                            pcSrcE = 1'b1; push_exp(NONE, 2'b00, 2'b00); end
                4: begin rst = 1'b0; push_exp(NONE, 2'b00, 2'b00); end
                5: begin load_use_5(); push_exp(LU, 2'b00, 2'b00); end
                default: push_exp(NONE, 2'b00, 2'b00);
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid_miss[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_raw_no_forward();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin regWriteE = 1'b1; rdE = 5'd3; rs2D = 5'd3; push_exp(RAW, 2'b00, 2'b00); end
                1: begin regWriteM = 1'b1; rdM = 5'd4; rs1D = 5'd4; push_exp(RAW, 2'b00, 2'b00); end
                2: begin rdM = 5'd4; rs1D = 5'd4; push_exp(NONE, 2'b00, 2'b00); end
                default: begin regWriteE = 1'b1; regWriteM = 1'b1; push_exp(NONE, 2'b00, 2'b00); end
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); o = obs();
            checks++;
            if (o !== e) begin errors++; $display("FAIL raw_no_fwd[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_cnt = '0;
        test_reset();
        test_load_use();
        test_forwarding();
        test_miss();
        test_branch_priority();
        test_reset_mid_miss();
        test_raw_no_forward();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
